// File: rtl/signed_or_unsigned_mac_pkg.sv
// Shared types and helpers for the streaming signed/unsigned multiply-accumulate stage.
package signed_or_unsigned_mac_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } burst_state_e;

    function automatic int acc_width(input int n, input int guard);
        return 2 * n + guard;
    endfunction

    // Width-generic saturating add on zero-padded operands (w must be below 64).
    function automatic logic [63:0] sat_add(input int w, input logic is_signed,
                                            input logic [63:0] lhs, input logic [63:0] rhs);
        logic [63:0] mask;
        logic [63:0] raw;
        logic [63:0] sum;
        mask = (64'd1 << w) - 64'd1;
        raw  = lhs + rhs;
        sum  = raw & mask;
        if (!is_signed) begin
            if (raw[w]) sum = mask;
        end else if ((lhs[w-1] == rhs[w-1]) && (sum[w-1] != lhs[w-1])) begin
            sum = lhs[w-1] ? (64'd1 << (w - 1)) : (mask >> 1);
        end
        return sum;
    endfunction

endpackage

// File: rtl/signed_or_unsigned_mac_if.sv
// Operand-beat and result handshake bundle for signed_or_unsigned_mac.
import signed_or_unsigned_mac_pkg::*;

interface signed_or_unsigned_mac_if #(
    parameter int N     = 8,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
);
    localparam int ACC_W = acc_width(N, GUARD);

    logic             up_valid;
    logic             up_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             signed_mul;
    logic             last;
    logic             down_valid;
    logic             down_ready;
    logic [ACC_W-1:0] down_acc;
    logic             down_signed;
    logic [CNT_W-1:0] down_count;
    logic             down_ovf;

    modport slave (
        input  up_valid, a, b, signed_mul, last, down_ready,
        output up_ready, down_valid, down_acc, down_signed, down_count, down_ovf
    );

    modport master (
        output up_valid, a, b, signed_mul, last, down_ready,
        input  up_ready, down_valid, down_acc, down_signed, down_count, down_ovf
    );
endinterface

// File: rtl/signed_or_unsigned_mac_mul.sv
// S1->S2 stage: extends operands per burst mode and registers the 2N-bit product.
import signed_or_unsigned_mac_pkg::*;

module mac_mul_stage #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           valid_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic           mode_i,
    input  logic           first_i,
    input  logic           last_i,
    output logic           valid_o,
    output logic [2*N-1:0] prod_o,
    output logic           mode_o,
    output logic           first_o,
    output logic           last_o
);
    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;
    logic [2*N-1:0] prod_d;
    logic [2*N-1:0] prod_q;
    logic           valid_q;
    logic           mode_q;
    logic           first_q;
    logic           last_q;

    // Low 2N bits of the extended product are exact for both signed and unsigned operands.
    always_comb begin
        a_ext  = mode_i ? {{N{a_i[N-1]}}, a_i} : {{N{1'b0}}, a_i};
        b_ext  = mode_i ? {{N{b_i[N-1]}}, b_i} : {{N{1'b0}}, b_i};
        prod_d = a_ext * b_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
            mode_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            prod_q  <= prod_d;
            mode_q  <= mode_i;
            first_q <= first_i;
            last_q  <= last_i;
        end
    end

    assign valid_o = valid_q;
    assign prod_o  = prod_q;
    assign mode_o  = mode_q;
    assign first_o = first_q;
    assign last_o  = last_q;
endmodule

// File: rtl/signed_or_unsigned_mac.sv
// Streaming MAC: bursts of operand pairs in, one accumulated result per burst out.
// Build option SIGNED_OR_UNSIGNED_MAC_SAT_EN: saturating accumulate instead of modulo wrap.
//
// state | meaning
// IDLE  | next accepted beat starts a burst and latches its signedness
// ACCUM | inside a burst; beats reuse the latched signedness
import signed_or_unsigned_mac_pkg::*;

module signed_or_unsigned_mac #(
    parameter int N     = 8,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    signed_or_unsigned_mac_if.slave mac_io
);
    localparam int ACC_W = acc_width(N, GUARD);
    localparam int P_W   = 2 * N;

    burst_state_e     state_q, state_d;
    logic             mode_lat_q, mode_lat_d;
    logic             en;
    logic             accept;
    logic             beat_first;
    logic             beat_mode;

    logic             s1_valid_q;
    logic [N-1:0]     s1_a_q;
    logic [N-1:0]     s1_b_q;
    logic             s1_mode_q;
    logic             s1_first_q;
    logic             s1_last_q;

    logic             s2_valid;
    logic [P_W-1:0]   s2_prod;
    logic             s2_mode;
    logic             s2_first;
    logic             s2_last;

    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [CNT_W-1:0] count_q;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum_full;
    logic             ovf_now;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;
    logic [CNT_W-1:0] count_next;

    logic             res_valid_q;
    logic [ACC_W-1:0] res_acc_q;
    logic             res_signed_q;
    logic [CNT_W-1:0] res_count_q;
    logic             res_ovf_q;

    // A single enable freezes the whole pipe while a result waits for its consumer.
    assign en     = !res_valid_q || mac_io.down_ready;
    assign accept = mac_io.up_valid && en;

    always_comb begin
        state_d    = state_q;
        mode_lat_d = mode_lat_q;
        beat_first = (state_q == IDLE);
        beat_mode  = (state_q == IDLE) ? mac_io.signed_mul : mode_lat_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    mode_lat_d = mac_io.signed_mul;
                    if (!mac_io.last) state_d = ACCUM;
                end
                ACCUM: begin
                    if (mac_io.last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_lat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_lat_q <= mode_lat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= accept;
            s1_a_q     <= mac_io.a;
            s1_b_q     <= mac_io.b;
            s1_mode_q  <= beat_mode;
            s1_first_q <= beat_first;
            s1_last_q  <= mac_io.last;
        end
    end

    mac_mul_stage #(.N(N)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .valid_i (s1_valid_q),
        .a_i     (s1_a_q),
        .b_i     (s1_b_q),
        .mode_i  (s1_mode_q),
        .first_i (s1_first_q),
        .last_i  (s1_last_q),
        .valid_o (s2_valid),
        .prod_o  (s2_prod),
        .mode_o  (s2_mode),
        .first_o (s2_first),
        .last_o  (s2_last)
    );

    always_comb begin
        base     = s2_first ? '0 : acc_q;
        ext      = s2_mode ? {{GUARD{s2_prod[P_W-1]}}, s2_prod} : {{GUARD{1'b0}}, s2_prod};
        sum_full = {1'b0, base} + {1'b0, ext};
        ovf_now  = s2_mode ? ((base[ACC_W-1] == ext[ACC_W-1]) && (sum_full[ACC_W-1] != base[ACC_W-1]))
                           : sum_full[ACC_W];
        ovf_next   = (s2_first ? 1'b0 : ovf_q) | ovf_now;
        count_next = s2_first ? CNT_W'(1) : ((count_q == '1) ? count_q : count_q + CNT_W'(1));
    end

`ifdef SIGNED_OR_UNSIGNED_MAC_SAT_EN
    logic [63:0] sat_res;
    assign sat_res  = sat_add(ACC_W, s2_mode, 64'(base), 64'(ext));
    assign acc_next = sat_res[ACC_W-1:0];
`else
    assign acc_next = sum_full[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else if (en && s2_valid) begin
            acc_q   <= acc_next;
            ovf_q   <= ovf_next;
            count_q <= count_next;
        end
    end

    // The result may reload on the very edge its predecessor is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_acc_q    <= '0;
            res_signed_q <= 1'b0;
            res_count_q  <= '0;
            res_ovf_q    <= 1'b0;
        end else if (en) begin
            if (s2_valid && s2_last) begin
                res_valid_q  <= 1'b1;
                res_acc_q    <= acc_next;
                res_signed_q <= s2_mode;
                res_count_q  <= count_next;
                res_ovf_q    <= ovf_next;
            end else begin
                res_valid_q  <= 1'b0;
            end
        end
    end

    assign mac_io.up_ready    = en;
    assign mac_io.down_valid  = res_valid_q;
    assign mac_io.down_acc    = res_acc_q;
    assign mac_io.down_signed = res_signed_q;
    assign mac_io.down_count  = res_count_q;
    assign mac_io.down_ovf    = res_ovf_q;
endmodule

// File: tb/tb_signed_or_unsigned_mac.sv
// Scoreboard bench for signed_or_unsigned_mac: directed bursts in, expected results queued.
import signed_or_unsigned_mac_pkg::*;

module tb_signed_or_unsigned_mac;
    localparam int N     = 8;
    localparam int GUARD = 8;
    localparam int CNT_W = 16;
    localparam int ACC_W = 2 * N + GUARD;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             sgn;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    signed_or_unsigned_mac_if #(.N(N), .GUARD(GUARD), .CNT_W(CNT_W)) mac_if ();

    signed_or_unsigned_mac #(.N(N), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mac_io (mac_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_res(input logic [ACC_W-1:0] acc, input logic sgn,
                              input logic [CNT_W-1:0] cnt, input logic ovf);
        res_t r;
        r.acc = acc; r.sgn = sgn; r.cnt = cnt; r.ovf = ovf;
        exp_q.push_back(r);
    endtask

    task automatic beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input logic l);
        int n;
        mac_if.up_valid   = 1'b1;
        mac_if.a          = a;
        mac_if.b          = b;
        mac_if.signed_mul = s;
        mac_if.last       = l;
        n = 0;
        @(negedge clk); #2;
        while (!mac_if.up_ready && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        if (!mac_if.up_ready) begin
            checks++; errors++;
            $display("FAIL beat_accept_timeout: up_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        mac_if.up_valid = 1'b0;
        mac_if.last     = 1'b0;
    endtask

    // Monitor: compares every presented result against the queue head; pops on handshake.
    initial begin
        res_t r;
        forever begin
            @(negedge clk); #2;
            if (rst_n) begin
                if (mac_if.down_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got acc 0x%0h count %0d, expected none",
                                 mac_if.down_acc, mac_if.down_count);
                    end else begin
                        r = exp_q[0];
                        chk("down_acc", 32'(mac_if.down_acc), 32'(r.acc));
                        chk("down_signed", 32'(mac_if.down_signed), 32'(r.sgn));
                        chk("down_count", 32'(mac_if.down_count), 32'(r.cnt));
                        chk("down_ovf", 32'(mac_if.down_ovf), 32'(r.ovf));
                        chk("up_ready_vs_down_ready", 32'(mac_if.up_ready), 32'(mac_if.down_ready));
                        if (mac_if.down_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("up_ready_no_result", 32'(mac_if.up_ready), 32'd1);
                end
            end
        end
    end

    initial begin
        int n;
        mac_if.up_valid   = 1'b0;
        mac_if.a          = '0;
        mac_if.b          = '0;
        mac_if.signed_mul = 1'b0;
        mac_if.last       = 1'b0;
        mac_if.down_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("reset_down_valid", 32'(mac_if.down_valid), 32'd0);
        chk("reset_down_acc", 32'(mac_if.down_acc), 32'd0);
        chk("reset_down_count", 32'(mac_if.down_count), 32'd0);
        chk("reset_down_ovf", 32'(mac_if.down_ovf), 32'd0);
        chk("reset_down_signed", 32'(mac_if.down_signed), 32'd0);
        chk("reset_up_ready", 32'(mac_if.up_ready), 32'd1);
        @(posedge clk); #1;

        // Unsigned single beat with latency probe.
        expect_res(24'd65025, 1'b0, 16'd1, 1'b0);
        beat(8'd255, 8'd255, 1'b0, 1'b1);
        idle();
        @(posedge clk); #1;
        chk("latency_e1_down_valid", 32'(mac_if.down_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency_e2_down_valid", 32'(mac_if.down_valid), 32'd1);
        repeat (2) @(posedge clk); #1;

        // Signed single beat: -1 * 2.
        expect_res(24'hFFFFFE, 1'b1, 16'd1, 1'b0);
        beat(8'hFF, 8'h02, 1'b1, 1'b1);

        // Mode lock: three signed products of 3 * -1 = -9 despite later signed_mul=0.
        expect_res(24'hFFFFF7, 1'b1, 16'd3, 1'b0);
        beat(8'd3, 8'hFF, 1'b1, 1'b0);
        beat(8'd3, 8'hFF, 1'b0, 1'b0);
        beat(8'd3, 8'hFF, 1'b0, 1'b1);
        idle();
        repeat (4) @(posedge clk); #1;

        // Backpressure: 5-cycle stall on the first result while later beats wait.
        expect_res(24'd1400, 1'b0, 16'd2, 1'b0);
        expect_res(24'hFFFFC5, 1'b1, 16'd2, 1'b0);
        expect_res(24'd4, 1'b0, 16'd1, 1'b0);
        fork
            begin
                beat(8'd10, 8'd20, 1'b0, 1'b0);
                beat(8'd30, 8'd40, 1'b0, 1'b1);
                beat(8'hFB, 8'd7, 1'b1, 1'b0);
                beat(8'd4, 8'hFA, 1'b1, 1'b1);
                beat(8'd2, 8'd2, 1'b0, 1'b1);
                idle();
            end
            begin
                n = 0;
                @(negedge clk);
                while (!mac_if.down_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (!mac_if.down_valid) begin
                    checks++; errors++;
                    $display("FAIL stall_wait_timeout: down_valid never rose");
                end
                mac_if.down_ready = 1'b0;
                repeat (5) @(negedge clk);
                mac_if.down_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk); #1;

        // Overflow: 259 * 65025 exceeds 2^24.
`ifdef SIGNED_OR_UNSIGNED_MAC_SAT_EN
        expect_res(24'hFFFFFF, 1'b0, 16'd259, 1'b1);
`else
        expect_res(24'd64259, 1'b0, 16'd259, 1'b1);
`endif
        for (int i = 0; i < 259; i++) beat(8'd255, 8'd255, 1'b0, (i == 258));
        expect_res(24'd6, 1'b0, 16'd1, 1'b0);
        beat(8'd2, 8'd3, 1'b0, 1'b1);
        idle();
        repeat (4) @(posedge clk); #1;

        // Reset mid-burst: partial burst discarded, next beat starts fresh.
        beat(8'd1, 8'd2, 1'b0, 1'b0);
        beat(8'd3, 8'd4, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("midreset_down_valid", 32'(mac_if.down_valid), 32'd0);
        chk("midreset_up_ready", 32'(mac_if.up_ready), 32'd1);
        @(posedge clk); #1;
        expect_res(24'd25, 1'b0, 16'd1, 1'b0);
        beat(8'd5, 8'd5, 1'b0, 1'b1);
        idle();

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
